// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier using an external ALU as its adder
module alu_mul_seq #(
    parameter int         WORD_W     = 32,
    parameter logic [3:0] ALU_ADD_OP = 4'b0010,
    parameter int         EARLY_EXIT = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_a,
    input  logic [WORD_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_prod,
    output logic              resp_zero,
    output logic              busy,
    output logic [3:0]        alu_op,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    input  logic [WORD_W-1:0] alu_out
);

    // One extra bit so the counter can reach WORD_W after the last RUN step.
    localparam int CNT_W = $clog2(WORD_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WORD_W-1:0]  r_acc;
    logic [WORD_W-1:0]  r_mcand;
    logic [WORD_W-1:0]  r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last_iter;

    // Last iteration: all WORD_W bits consumed, or no set multiplier bits remain above bit 0.
    assign w_last_iter = (r_cnt == CNT_W'(WORD_W - 1)) ||
                         ((EARLY_EXIT != 0) && ((r_mplier >> 1) == '0));

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)   w_next_state = S_RUN;
            S_RUN:   if (w_last_iter) w_next_state = S_DONE;
            S_DONE:  if (resp_ready)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, then one multiplier bit per RUN cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= req_a;
                        r_mplier <= req_b;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_out;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs depend only on registers, so the ALU loop has no combinational path from inputs.
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_DONE);
        busy       = (r_state != S_IDLE);
        resp_prod  = r_acc;
        resp_zero  = (r_acc == '0);
        alu_op     = ALU_ADD_OP;
        alu_a      = r_acc;
        alu_b      = r_mcand;
    end

endmodule
